decode_control_stage: RTL and testbench
=======================================

DECODE_CONTROL_STAGE -- requirements
Module: decode_control_stage

Interface
REQ-001 Parameter ENABLE_M_EXT, default 1, meaning decode RV32M (MUL/DIV) as legal; 0 makes them illegal.
REQ-002 Parameter ENABLE_CSR_IMM, default 1, meaning decode CSRRWI/CSRRSI/CSRRCI as legal; 0 makes them illegal.
REQ-003 clk  input  1  single clock; all state on rising edge.
REQ-004 rst_n  input  1  reset, asynchronous assert, active-low.
REQ-005 flush  input  1  synchronous kill of all held entries.
REQ-006 in_valid  input  1  upstream instruction valid.
REQ-007 in_ready  output  1  stage can accept; registered, not combinationally dependent on out_ready.
REQ-008 instruction_in  input  32  raw RV32 instruction.
REQ-009 pc_in  input  32  instruction address.
REQ-010 out_valid  output  1  decoded entry valid.
REQ-011 out_ready  input  1  downstream accepts.
REQ-012 control_out  output  CONTROL_WIDTH  packed control bundle (fields per REQ-016).
REQ-013 instruction_out, pc_out  output  32 each  passthrough of the entry presented.

Function
REQ-014 Transfer in when in_valid && in_ready; out when out_valid && out_ready; latency 1 cycle; sustained throughput 1 per cycle when out_ready=1.
REQ-015 Storage: output register plus one skid entry; in_ready = skid entry empty; entries leave strictly in arrival order.
REQ-016 Bundle fields: branch, jump, memory_read_enable, memory_write_enable, memory_to_register_select, alu_operation_code[3:0], alu_source_select, alu_source_a_select, register_write_enable, csr_write_enable, csr_to_register_select, csr_immediate_select, is_machine_return, is_environment_call, is_mul_div, illegal_instruction.
REQ-017 Decode is combinational on instruction_in, captured at transfer-in; all fields default 0.
REQ-018 R-type 0110011: register_write_enable=1, alu_operation_code=0010; funct7=0000001 with ENABLE_M_EXT=1 sets is_mul_div=1, alu_operation_code=0101; with ENABLE_M_EXT=0 it is illegal.
REQ-019 OP-IMM 0010011: alu_source_select=1, register_write_enable=1, alu_operation_code=0011.
REQ-020 LOAD 0000011: alu_source_select, memory_to_register_select, register_write_enable, memory_read_enable =1, code 0000; STORE 0100011: alu_source_select, memory_write_enable =1, code 0000.
REQ-021 BRANCH 1100011: branch=1, code 0001; JAL 1101111: jump, register_write_enable =1; JALR 1100111: jump, register_write_enable, alu_source_select =1, code 0000.
REQ-022 LUI 0110111: alu_source_select, register_write_enable =1, code 0100; AUIPC 0010111: adds alu_source_a_select=1, code 0000.
REQ-023 MISC-MEM 0001111: legal, all enables 0.
REQ-024 SYSTEM funct3=000: funct7=0000000 & rs2=00000 -> is_environment_call; funct7=0011000 & rs2=00010 -> is_machine_return; otherwise illegal.
REQ-025 SYSTEM funct3 001/010/011 (and 101/110/111 when ENABLE_CSR_IMM=1): register_write_enable=1, csr_to_register_select=1; csr_immediate_select=funct3[2]; csr_write_enable=1 for x01, else (rs1 field != 0).
REQ-026 SYSTEM funct3=100, or 1xx with ENABLE_CSR_IMM=0, and any other opcode: illegal_instruction=1, every other field 0.
REQ-027 flush: next cycle out_valid=0, skid empty, in_ready=1; an input offered in the flush cycle is dropped; flush overrides simultaneous transfer-in and transfer-out.
REQ-028 Simultaneous transfer-in and transfer-out with skid empty: output register reloads, no skid use.
REQ-029 out_ready=0 with output full: arriving entry goes to skid; in_ready=0 next cycle; skid drains to output on first out_ready=1.

Reset
REQ-030 While rst_n=0: out_valid=0, skid empty, in_ready=1, control_out/pc_out/instruction_out all 0; first transfer-in possible on the first clk edge after release.

Structure
REQ-031 Shared package holds opcode constants, alu_operation_code encodings, bundle field offsets and CONTROL_WIDTH.
REQ-032 Combinational decoder is sub-module decode_control_logic (parameters passed down); this module owns handshake and storage only.

Verification
REQ-033 ADD 0x00208033, out_ready=1 -> next cycle out_valid=1, register_write_enable=1, alu_operation_code=0010, illegal=0.
REQ-034 MUL 0x022080B3 -> ENABLE_M_EXT=1: is_mul_div=1, code 0101; ENABLE_M_EXT=0: illegal_instruction=1, register_write_enable=0.
REQ-035 out_ready=0, push 0x00000013 then 0x30200073 -> in_ready=0 after second; release -> NOP then is_machine_return=1, in order.
REQ-036 CSRRSI 0x30006073 -> csr_immediate_select=1, csr_write_enable=0; 0x0000007F -> illegal_instruction=1.
REQ-037 Both entries full, flush=1 with in_valid=1 -> next cycle out_valid=0, in_ready=1, no entry ever emitted.
REQ-038 rst_n low mid-stream with entries held -> out_valid=0 immediately, in_ready=1, control_out=0.

Source files
------------

// File: rtl/decode_control_stage_pkg.sv
// Shared definitions for the decode/control stage: opcodes, ALU encodings,
// control bundle layout and the entry format held in the stage registers.
package decode_control_stage_pkg;

   localparam logic [6:0] OPC_OP       = 7'b0110011;
   localparam logic [6:0] OPC_OP_IMM   = 7'b0010011;
   localparam logic [6:0] OPC_LOAD     = 7'b0000011;
   localparam logic [6:0] OPC_STORE    = 7'b0100011;
   localparam logic [6:0] OPC_BRANCH   = 7'b1100011;
   localparam logic [6:0] OPC_JAL      = 7'b1101111;
   localparam logic [6:0] OPC_JALR     = 7'b1100111;
   localparam logic [6:0] OPC_LUI      = 7'b0110111;
   localparam logic [6:0] OPC_AUIPC    = 7'b0010111;
   localparam logic [6:0] OPC_MISC_MEM = 7'b0001111;
   localparam logic [6:0] OPC_SYSTEM   = 7'b1110011;

   localparam logic [6:0] F7_MULDIV = 7'b0000001;
   localparam logic [6:0] F7_MRET   = 7'b0011000;
   localparam logic [4:0] RS2_MRET  = 5'b00010;

   localparam logic [3:0] ALU_ADD    = 4'b0000;
   localparam logic [3:0] ALU_BRANCH = 4'b0001;
   localparam logic [3:0] ALU_REG    = 4'b0010;
   localparam logic [3:0] ALU_IMM    = 4'b0011;
   localparam logic [3:0] ALU_LUI    = 4'b0100;
   localparam logic [3:0] ALU_MULDIV = 4'b0101;

   // Bit offsets inside control_out; must agree with ctrl_t below (LSB = branch).
   localparam int OFF_BRANCH                    = 0;
   localparam int OFF_JUMP                      = 1;
   localparam int OFF_MEMORY_READ_ENABLE        = 2;
   localparam int OFF_MEMORY_WRITE_ENABLE       = 3;
   localparam int OFF_MEMORY_TO_REGISTER_SELECT = 4;
   localparam int OFF_ALU_OPERATION_CODE        = 5;
   localparam int OFF_ALU_SOURCE_SELECT         = 9;
   localparam int OFF_ALU_SOURCE_A_SELECT       = 10;
   localparam int OFF_REGISTER_WRITE_ENABLE     = 11;
   localparam int OFF_CSR_WRITE_ENABLE          = 12;
   localparam int OFF_CSR_TO_REGISTER_SELECT    = 13;
   localparam int OFF_CSR_IMMEDIATE_SELECT      = 14;
   localparam int OFF_IS_MACHINE_RETURN         = 15;
   localparam int OFF_IS_ENVIRONMENT_CALL       = 16;
   localparam int OFF_IS_MUL_DIV                = 17;
   localparam int OFF_ILLEGAL_INSTRUCTION       = 18;
   localparam int CONTROL_WIDTH                 = 19;

   typedef struct packed {
      logic       illegal_instruction;
      logic       is_mul_div;
      logic       is_environment_call;
      logic       is_machine_return;
      logic       csr_immediate_select;
      logic       csr_to_register_select;
      logic       csr_write_enable;
      logic       register_write_enable;
      logic       alu_source_a_select;
      logic       alu_source_select;
      logic [3:0] alu_operation_code;
      logic       memory_to_register_select;
      logic       memory_write_enable;
      logic       memory_read_enable;
      logic       jump;
      logic       branch;
   } ctrl_t;

   typedef struct packed {
      logic [CONTROL_WIDTH-1:0] control;
      logic [31:0]              instruction;
      logic [31:0]              pc;
   } entry_t;

   function automatic ctrl_t illegal_ctrl();
      ctrl_t c;
      c = '0;
      c.illegal_instruction = 1'b1;
      return c;
   endfunction

endpackage

// File: rtl/decode_control_logic.sv
// Purely combinational RV32I(+M, +Zicsr) decoder producing the control bundle.
// Anything not recognised collapses to a bundle with only illegal_instruction set.
module decode_control_logic
   import decode_control_stage_pkg::*;
#(
   parameter bit ENABLE_M_EXT   = 1'b1,
   parameter bit ENABLE_CSR_IMM = 1'b1
) (
   input  logic [31:0]              instruction,
   output logic [CONTROL_WIDTH-1:0] control
);

   logic [6:0] opcode;
   logic [2:0] funct3;
   logic [6:0] funct7;
   logic [4:0] rs1;
   logic [4:0] rs2;
   logic       unused_rd;
   ctrl_t      c;

   assign opcode    = instruction[6:0];
   assign funct3    = instruction[14:12];
   assign funct7    = instruction[31:25];
   assign rs1       = instruction[19:15];
   assign rs2       = instruction[24:20];
   assign unused_rd = ^instruction[11:7];

   always_comb begin
      c = '0;
      unique case (opcode)
         OPC_OP: begin
            if (funct7 == F7_MULDIV) begin
               if (ENABLE_M_EXT) begin
                  c.register_write_enable = 1'b1;
                  c.is_mul_div            = 1'b1;
                  c.alu_operation_code    = ALU_MULDIV;
               end else begin
                  c = illegal_ctrl();
               end
            end else begin
               c.register_write_enable = 1'b1;
               c.alu_operation_code    = ALU_REG;
            end
         end
         OPC_OP_IMM: begin
            c.alu_source_select     = 1'b1;
            c.register_write_enable = 1'b1;
            c.alu_operation_code    = ALU_IMM;
         end
         OPC_LOAD: begin
            c.alu_source_select         = 1'b1;
            c.memory_to_register_select = 1'b1;
            c.register_write_enable     = 1'b1;
            c.memory_read_enable        = 1'b1;
            c.alu_operation_code        = ALU_ADD;
         end
         OPC_STORE: begin
            c.alu_source_select   = 1'b1;
            c.memory_write_enable = 1'b1;
            c.alu_operation_code  = ALU_ADD;
         end
         OPC_BRANCH: begin
            c.branch             = 1'b1;
            c.alu_operation_code = ALU_BRANCH;
         end
         OPC_JAL: begin
            c.jump                  = 1'b1;
            c.register_write_enable = 1'b1;
         end
         OPC_JALR: begin
            c.jump                  = 1'b1;
            c.register_write_enable = 1'b1;
            c.alu_source_select     = 1'b1;
            c.alu_operation_code    = ALU_ADD;
         end
         OPC_LUI: begin
            c.alu_source_select     = 1'b1;
            c.register_write_enable = 1'b1;
            c.alu_operation_code    = ALU_LUI;
         end
         OPC_AUIPC: begin
            c.alu_source_select     = 1'b1;
            c.alu_source_a_select   = 1'b1;
            c.register_write_enable = 1'b1;
            c.alu_operation_code    = ALU_ADD;
         end
         OPC_MISC_MEM: begin
            c = '0;
         end
         OPC_SYSTEM: begin
            unique case (funct3)
               3'b000: begin
                  if (funct7 == 7'b0 && rs2 == 5'b0)
                     c.is_environment_call = 1'b1;
                  else if (funct7 == F7_MRET && rs2 == RS2_MRET)
                     c.is_machine_return = 1'b1;
                  else
                     c = illegal_ctrl();
               end
               3'b001, 3'b010, 3'b011, 3'b101, 3'b110, 3'b111: begin
                  if (funct3[2] && !ENABLE_CSR_IMM) begin
                     c = illegal_ctrl();
                  end else begin
                     c.register_write_enable  = 1'b1;
                     c.csr_to_register_select = 1'b1;
                     c.csr_immediate_select   = funct3[2];
                     // CSRRW/CSRRWI always write; set/clear forms only with a nonzero source
                     c.csr_write_enable       = (funct3[1:0] == 2'b01) ? 1'b1 : (rs1 != 5'b0);
                  end
               end
               default: c = illegal_ctrl();
            endcase
         end
         default: c = illegal_ctrl();
      endcase
   end

   assign control = c;

endmodule

// File: rtl/decode_control_stage.sv
// Decode stage: one output register plus a skid entry, in-order, flushable.
// in_ready comes straight from the skid flag so it never depends on out_ready.
module decode_control_stage
   import decode_control_stage_pkg::*;
#(
   parameter bit ENABLE_M_EXT   = 1'b1,
   parameter bit ENABLE_CSR_IMM = 1'b1
) (
   input  logic                     clk,
   input  logic                     rst_n,
   input  logic                     flush,
   input  logic                     in_valid,
   output logic                     in_ready,
   input  logic [31:0]              instruction_in,
   input  logic [31:0]              pc_in,
   output logic                     out_valid,
   input  logic                     out_ready,
   output logic [CONTROL_WIDTH-1:0] control_out,
   output logic [31:0]              instruction_out,
   output logic [31:0]              pc_out
);

   logic [CONTROL_WIDTH-1:0] decoded;
   entry_t                   in_entry;
   entry_t                   out_q;
   entry_t                   skid_q;
   logic                     skid_valid;
   logic                     push;
   logic                     pop;

   decode_control_logic #(
      .ENABLE_M_EXT   (ENABLE_M_EXT),
      .ENABLE_CSR_IMM (ENABLE_CSR_IMM)
   ) u_decode (
      .instruction (instruction_in),
      .control     (decoded)
   );

   assign in_entry = '{control: decoded, instruction: instruction_in, pc: pc_in};
   assign in_ready = ~skid_valid;
   assign push     = in_valid & in_ready;
   assign pop      = out_valid & out_ready;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         out_q      <= '0;
         skid_q     <= '0;
         out_valid  <= 1'b0;
         skid_valid <= 1'b0;
      end else if (flush) begin
         out_valid  <= 1'b0;
         skid_valid <= 1'b0;
      end else if (!out_valid || pop) begin
         // Output slot frees up: the older skid entry has priority over new input.
         // While the skid is occupied in_ready is low, so push cannot coincide.
         if (skid_valid) begin
            out_q      <= skid_q;
            out_valid  <= 1'b1;
            skid_valid <= 1'b0;
         end else begin
            out_valid <= push;
            if (push)
               out_q <= in_entry;
         end
      end else if (push) begin
         skid_q     <= in_entry;
         skid_valid <= 1'b1;
      end
   end

   assign control_out     = out_q.control;
   assign instruction_out = out_q.instruction;
   assign pc_out          = out_q.pc;

endmodule

// File: tb/tb_decode_control_stage.sv
// Bench for decode_control_stage: default-parameter DUT plus a reduced-ISA DUT,
// scoreboarded against hand-derived control bundles.
module tb_decode_control_stage;
   import decode_control_stage_pkg::*;

   typedef logic [CONTROL_WIDTH-1:0] cw_t;
   typedef struct {
      cw_t         ctrl;
      logic [31:0] ins;
      logic [31:0] pc;
   } exp_t;

   localparam cw_t B_BR   = cw_t'(1) << OFF_BRANCH;
   localparam cw_t B_JMP  = cw_t'(1) << OFF_JUMP;
   localparam cw_t B_MRE  = cw_t'(1) << OFF_MEMORY_READ_ENABLE;
   localparam cw_t B_MWE  = cw_t'(1) << OFF_MEMORY_WRITE_ENABLE;
   localparam cw_t B_M2R  = cw_t'(1) << OFF_MEMORY_TO_REGISTER_SELECT;
   localparam cw_t B_SRC  = cw_t'(1) << OFF_ALU_SOURCE_SELECT;
   localparam cw_t B_SRCA = cw_t'(1) << OFF_ALU_SOURCE_A_SELECT;
   localparam cw_t B_RWE  = cw_t'(1) << OFF_REGISTER_WRITE_ENABLE;
   localparam cw_t B_CWE  = cw_t'(1) << OFF_CSR_WRITE_ENABLE;
   localparam cw_t B_C2R  = cw_t'(1) << OFF_CSR_TO_REGISTER_SELECT;
   localparam cw_t B_CIMM = cw_t'(1) << OFF_CSR_IMMEDIATE_SELECT;
   localparam cw_t B_MRET = cw_t'(1) << OFF_IS_MACHINE_RETURN;
   localparam cw_t B_ECAL = cw_t'(1) << OFF_IS_ENVIRONMENT_CALL;
   localparam cw_t B_MD   = cw_t'(1) << OFF_IS_MUL_DIV;
   localparam cw_t B_ILL  = cw_t'(1) << OFF_ILLEGAL_INSTRUCTION;
   localparam int  NV     = 20;

   logic        clk = 1'b0;
   logic        rst_n;
   logic        flush, in_valid, in_ready, out_valid, out_ready;
   logic [31:0] instruction_in, pc_in, instruction_out, pc_out;
   cw_t         control_out;

   logic        in_valid1, in_ready1, out_valid1;
   logic [31:0] instruction_in1, instruction_out1, pc_out1;
   cw_t         control_out1;
   logic        flush1 = 1'b0;
   logic        out_ready1 = 1'b1;
   logic [31:0] pc_in1 = 32'h0;

   int          vectors = 0;
   int          errors  = 0;
   exp_t        sb0[$];
   exp_t        sb1[$];
   logic [31:0] vec_ins[NV];
   cw_t         vec_exp[NV];
   logic [31:0] pc_ctr = 32'h1000;

   always #5 clk = ~clk;

   decode_control_stage dut (
      .clk(clk), .rst_n(rst_n), .flush(flush), .in_valid(in_valid), .in_ready(in_ready),
      .instruction_in(instruction_in), .pc_in(pc_in), .out_valid(out_valid),
      .out_ready(out_ready), .control_out(control_out),
      .instruction_out(instruction_out), .pc_out(pc_out)
   );

   decode_control_stage #(.ENABLE_M_EXT(1'b0), .ENABLE_CSR_IMM(1'b0)) dut_min (
      .clk(clk), .rst_n(rst_n), .flush(flush1), .in_valid(in_valid1), .in_ready(in_ready1),
      .instruction_in(instruction_in1), .pc_in(pc_in1), .out_valid(out_valid1),
      .out_ready(out_ready1), .control_out(control_out1),
      .instruction_out(instruction_out1), .pc_out(pc_out1)
   );

   function automatic cw_t op(input logic [3:0] code);
      return cw_t'(code) << OFF_ALU_OPERATION_CODE;
   endfunction

   // Scoreboard monitors: pop the oldest expectation whenever an entry leaves.
   always @(negedge clk) begin
      if (rst_n && !flush && out_valid && out_ready) begin
         vectors++;
         if (sb0.size() == 0) begin
            errors++;
            $display("FAIL unexpected_output: got ins=%h ctrl=%h, required no output", instruction_out, control_out);
         end else begin
            exp_t e;
            e = sb0.pop_front();
            if (control_out !== e.ctrl || instruction_out !== e.ins || pc_out !== e.pc) begin
               errors++;
               $display("FAIL out_entry: got ins=%h pc=%h ctrl=%h, required ins=%h pc=%h ctrl=%h",
                        instruction_out, pc_out, control_out, e.ins, e.pc, e.ctrl);
            end
         end
      end
   end

   always @(negedge clk) begin
      if (rst_n && out_valid1 && out_ready1) begin
         vectors++;
         if (sb1.size() == 0) begin
            errors++;
            $display("FAIL unexpected_output_min: got ins=%h, required no output", instruction_out1);
         end else begin
            exp_t e;
            e = sb1.pop_front();
            if (control_out1 !== e.ctrl || instruction_out1 !== e.ins) begin
               errors++;
               $display("FAIL out_entry_min: got ins=%h ctrl=%h, required ins=%h ctrl=%h",
                        instruction_out1, control_out1, e.ins, e.ctrl);
            end
         end
      end
   end

   // Called at posedge+1; holds in_valid until accepted, returns at posedge+1.
   task automatic send(input logic [31:0] ins, input cw_t ctrl);
      exp_t e;
      in_valid = 1'b1;
      instruction_in = ins;
      pc_in = pc_ctr;
      for (int t = 0; t < 200; t++) begin
         @(negedge clk);
         if (in_ready) begin
            e.ctrl = ctrl; e.ins = ins; e.pc = pc_ctr;
            sb0.push_back(e);
            @(posedge clk); #1;
            in_valid = 1'b0;
            pc_ctr += 4;
            return;
         end
         @(posedge clk); #1;
      end
      vectors++; errors++;
      $display("FAIL send_timeout: in_ready stayed 0 for ins=%h, required 1", ins);
      in_valid = 1'b0;
   endtask

   task automatic expect_drained(input string name);
      repeat (4) @(posedge clk);
      #1;
      vectors++;
      if (sb0.size() !== 0) begin
         errors++;
         $display("FAIL %s: got %0d entries outstanding, required 0", name, sb0.size());
      end
   endtask

   task automatic init_vectors();
      vec_ins[0]  = 32'h00208033; vec_exp[0]  = B_RWE | op(4'b0010);                 // add
      vec_ins[1]  = 32'h022080B3; vec_exp[1]  = B_RWE | B_MD | op(4'b0101);          // mul
      vec_ins[2]  = 32'h00000013; vec_exp[2]  = B_SRC | B_RWE | op(4'b0011);         // nop
      vec_ins[3]  = 32'h0000A083; vec_exp[3]  = B_SRC | B_M2R | B_RWE | B_MRE;       // lw
      vec_ins[4]  = 32'h0020A023; vec_exp[4]  = B_SRC | B_MWE;                       // sw
      vec_ins[5]  = 32'h00208063; vec_exp[5]  = B_BR | op(4'b0001);                  // beq
      vec_ins[6]  = 32'h0000006F; vec_exp[6]  = B_JMP | B_RWE;                       // jal
      vec_ins[7]  = 32'h000080E7; vec_exp[7]  = B_JMP | B_RWE | B_SRC;               // jalr
      vec_ins[8]  = 32'h000010B7; vec_exp[8]  = B_SRC | B_RWE | op(4'b0100);         // lui
      vec_ins[9]  = 32'h00001097; vec_exp[9]  = B_SRC | B_SRCA | B_RWE;              // auipc
      vec_ins[10] = 32'h0000000F; vec_exp[10] = '0;                                  // fence
      vec_ins[11] = 32'h00000073; vec_exp[11] = B_ECAL;                              // ecall
      vec_ins[12] = 32'h30200073; vec_exp[12] = B_MRET;                              // mret
      vec_ins[13] = 32'h00100073; vec_exp[13] = B_ILL;                               // ebreak
      vec_ins[14] = 32'h30509073; vec_exp[14] = B_RWE | B_C2R | B_CWE;               // csrrw
      vec_ins[15] = 32'h30002073; vec_exp[15] = B_RWE | B_C2R;                       // csrrs rs1=0
      vec_ins[16] = 32'h30006073; vec_exp[16] = B_RWE | B_C2R | B_CIMM;              // csrrsi 0
      vec_ins[17] = 32'h3050D073; vec_exp[17] = B_RWE | B_C2R | B_CIMM | B_CWE;      // csrrwi
      vec_ins[18] = 32'h00004073; vec_exp[18] = B_ILL;                               // system f3=100
      vec_ins[19] = 32'h0000007F; vec_exp[19] = B_ILL;                               // bad opcode
   endtask

   task automatic test_reset();
      rst_n = 1'b0; flush = 1'b0; in_valid = 1'b0; out_ready = 1'b1;
      instruction_in = '0; pc_in = '0; in_valid1 = 1'b0; instruction_in1 = '0;
      repeat (2) @(posedge clk);
      @(negedge clk);
      vectors++;
      if (out_valid !== 1'b0 || in_ready !== 1'b1 || control_out !== '0 ||
          pc_out !== '0 || instruction_out !== '0 || out_valid1 !== 1'b0) begin
         errors++;
         $display("FAIL reset_state: got ov=%b ir=%b ctrl=%h pc=%h ins=%h ov1=%b, required 0 1 0 0 0 0",
                  out_valid, in_ready, control_out, pc_out, instruction_out, out_valid1);
      end
      rst_n = 1'b1;
      @(posedge clk); #1;
   endtask

   // Back-to-back stream with out_ready=1: one acceptance per cycle.
   task automatic test_decode_stream();
      time t0;
      out_ready = 1'b1;
      t0 = $time;
      for (int i = 0; i < NV; i++) send(vec_ins[i], vec_exp[i]);
      vectors++;
      if ($time - t0 !== NV * 10) begin
         errors++;
         $display("FAIL throughput: got %0t for %0d entries, required %0d", $time - t0, NV, NV * 10);
      end
      expect_drained("stream_drain");
   endtask

   task automatic test_reduced_isa();
      logic [31:0] ins[3];
      cw_t         ex[3];
      exp_t        e;
      ins[0] = 32'h022080B3; ex[0] = B_ILL;
      ins[1] = 32'h30006073; ex[1] = B_ILL;
      ins[2] = 32'h00208033; ex[2] = B_RWE | op(4'b0010);
      for (int i = 0; i < 3; i++) begin
         in_valid1 = 1'b1; instruction_in1 = ins[i];
         @(negedge clk);
         vectors++;
         if (in_ready1 !== 1'b1) begin
            errors++;
            $display("FAIL min_in_ready: got %b, required 1", in_ready1);
         end
         e.ctrl = ex[i]; e.ins = ins[i]; e.pc = '0;
         sb1.push_back(e);
         @(posedge clk); #1;
      end
      in_valid1 = 1'b0;
      repeat (3) @(posedge clk);
      #1;
      vectors++;
      if (sb1.size() !== 0) begin
         errors++;
         $display("FAIL min_drain: got %0d outstanding, required 0", sb1.size());
      end
   endtask

   task automatic test_backpressure();
      out_ready = 1'b0;
      send(32'h00000013, B_SRC | B_RWE | op(4'b0011));
      send(32'h30200073, B_MRET);
      @(negedge clk);
      vectors++;
      if (in_ready !== 1'b0 || out_valid !== 1'b1 || instruction_out !== 32'h00000013) begin
         errors++;
         $display("FAIL skid_full: got ir=%b ov=%b ins=%h, required 0 1 00000013", in_ready, out_valid, instruction_out);
      end
      @(posedge clk); #1;
      out_ready = 1'b1;
      expect_drained("skid_drain");
   endtask

   task automatic test_flush();
      out_ready = 1'b0;
      send(32'h00208033, B_RWE | op(4'b0010));
      send(32'h022080B3, B_RWE | B_MD | op(4'b0101));
      in_valid = 1'b1; instruction_in = 32'h00000013; flush = 1'b1;
      @(posedge clk); #1;
      flush = 1'b0; in_valid = 1'b0;
      sb0.delete();
      @(negedge clk);
      vectors++;
      if (out_valid !== 1'b0 || in_ready !== 1'b1) begin
         errors++;
         $display("FAIL flush_full: got ov=%b ir=%b, required 0 1", out_valid, in_ready);
      end
      // Offer with flush while the stage is empty and ready: must be dropped.
      @(posedge clk); #1;
      out_ready = 1'b1; in_valid = 1'b1; instruction_in = 32'h0000006F; flush = 1'b1;
      @(posedge clk); #1;
      flush = 1'b0; in_valid = 1'b0;
      @(negedge clk);
      vectors++;
      if (out_valid !== 1'b0) begin
         errors++;
         $display("FAIL flush_drop: got ov=%b, required 0", out_valid);
      end
      @(posedge clk); #1;
      expect_drained("flush_nothing_emitted");
   endtask

   task automatic test_reset_mid();
      out_ready = 1'b0;
      send(32'h00000073, B_ECAL);
      send(32'h0000A083, B_SRC | B_M2R | B_RWE | B_MRE);
      vectors++;
      if (out_valid !== 1'b1 || in_ready !== 1'b0) begin
         errors++;
         $display("FAIL pre_reset_full: got ov=%b ir=%b, required 1 0", out_valid, in_ready);
      end
      #2 rst_n = 1'b0;
      #1;
      vectors++;
      if (out_valid !== 1'b0 || in_ready !== 1'b1 || control_out !== '0) begin
         errors++;
         $display("FAIL async_reset: got ov=%b ir=%b ctrl=%h, required 0 1 0", out_valid, in_ready, control_out);
      end
      sb0.delete();
      @(negedge clk);
      rst_n = 1'b1;
      @(posedge clk); #1;
      out_ready = 1'b1;
      send(32'h00208033, B_RWE | op(4'b0010));
      expect_drained("post_reset");
   endtask

   task automatic test_random_backpressure();
      bit done = 1'b0;
      fork
         begin
            for (int i = 0; i < 40; i++) begin
               int idx;
               idx = $urandom_range(0, NV - 1);
               send(vec_ins[idx], vec_exp[idx]);
            end
            done = 1'b1;
         end
         begin
            while (!done) begin
               @(posedge clk); #1;
               out_ready = 1'($urandom_range(0, 1));
            end
         end
      join
      out_ready = 1'b1;
      expect_drained("random_drain");
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: simulation time limit reached, required completion");
      $fatal(1, "watchdog");
   end

   initial begin
      init_vectors();
      test_reset();
      test_decode_stream();
      test_reduced_isa();
      test_backpressure();
      test_flush();
      test_reset_mid();
      test_random_backpressure();
      $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
      $finish;
   end

endmodule
